// File: rtl/lives_manager.sv
// lives_manager
// Turns the raw sprite-overlap hit level into the collision flag and lives
// count that the game state machine consumes. It also sequences the
// respawn pulse and the invulnerability window that follow a hit.
//
// Ports
//   i_Clk           system clock
//   i_Reset_N       synchronous active-low reset
//   i_Game_State    00 IDLE, 01 RUN, 10 WIN, 11 CLEAN
//   i_Hit           raw overlap level; may stay high for many cycles
//   o_Collision     held high for RESPAWN_CYCLES after an accepted hit
//   o_Lives         remaining lives
//   o_Respawn       one-cycle pulse; the frog returns to its start position
//   o_Invulnerable  high for INVULN_CYCLES after the respawn; drives sprite blink
//   o_Game_Over     one-cycle pulse when the last life is lost
//   o_State         debug view of the internal FSM (00 ARMED, 01 HIT, 10 INVULN, 11 DEAD)
//
// Handshake: there is no valid/ready traffic here. Every output is a plain
// registered level or a single-cycle pulse. It becomes visible the cycle
// after the edge that sampled its cause.
module lives_manager #(
  parameter int START_LIVES    = 3,
  parameter int LIVES_W        = 3,
  parameter int RESPAWN_CYCLES = 12_500_000,
  parameter int INVULN_CYCLES  = 25_000_000
) (
  input  logic               i_Clk,
  input  logic               i_Reset_N,
  input  logic [1:0]         i_Game_State,
  input  logic               i_Hit,
  output logic               o_Collision,
  output logic [LIVES_W-1:0] o_Lives,
  output logic               o_Respawn,
  output logic               o_Invulnerable,
  output logic               o_Game_Over,
  output logic [1:0]         o_State
);

  typedef enum logic [1:0] {
    ARMED  = 2'b00,
    HIT    = 2'b01,
    INVULN = 2'b10,
    DEAD   = 2'b11
  } state_t;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_RUN  = 2'b01;

  localparam int MAX_C = (RESPAWN_CYCLES > INVULN_CYCLES) ? RESPAWN_CYCLES : INVULN_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0]   RESP_LOAD   = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   INVULN_LOAD = CNT_W'(INVULN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_ZERO  = '0;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LIVES_W-1:0] lives, lives_n;
  logic               collision, collision_n;
  logic               respawn, respawn_n;
  logic               invuln, invuln_n;
  logic               game_over, game_over_n;
  logic               hit_prev;
  logic               hit_ev;

  // A hit counts only on a rising edge of the raw level. hit_prev tracks i_Hit
  // in every state, so a level held through a window never re-triggers.
  assign hit_ev = i_Hit & ~hit_prev;

  // State register
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_N) begin
      state     <= ARMED;
      cnt       <= CNT_ZERO;
      lives     <= LIVES_START;
      collision <= 1'b0;
      respawn   <= 1'b0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
      hit_prev  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lives     <= lives_n;
      collision <= collision_n;
      respawn   <= respawn_n;
      invuln    <= invuln_n;
      game_over <= game_over_n;
      hit_prev  <= i_Hit;
    end
  end

  // Next-state logic
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lives_n     = lives;
    collision_n = collision;
    invuln_n    = invuln;
    respawn_n   = 1'b0;
    game_over_n = 1'b0;

    if (i_Game_State == GS_IDLE) begin
      // IDLE overrides everything, including open windows and a coincident hit.
      state_n     = ARMED;
      cnt_n       = CNT_ZERO;
      lives_n     = LIVES_START;
      collision_n = 1'b0;
      invuln_n    = 1'b0;
    end else begin
      unique case (state)
        ARMED: begin
          if (hit_ev && (i_Game_State == GS_RUN)) begin
            if (lives > LIVES_ONE) begin
              lives_n     = lives - LIVES_ONE;
              collision_n = 1'b1;
              cnt_n       = RESP_LOAD;
              state_n     = HIT;
            end else if (lives == LIVES_ONE) begin
              // The last life goes without a collision flag, so the game
              // machine drops straight back to IDLE instead of passing CLEAN.
              lives_n     = LIVES_ZERO;
              game_over_n = 1'b1;
              state_n     = DEAD;
            end
          end
        end
        HIT: begin
          // The timer runs in every non-IDLE game state, WIN included.
          if (cnt == CNT_ZERO) begin
            collision_n = 1'b0;
            respawn_n   = 1'b1;
            invuln_n    = 1'b1;
            cnt_n       = INVULN_LOAD;
            state_n     = INVULN;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        INVULN: begin
          if (cnt == CNT_ZERO) begin
            invuln_n = 1'b0;
            state_n  = ARMED;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        DEAD: begin
          state_n = DEAD;
        end
        default: state_n = ARMED;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_Collision    = collision;
    o_Lives        = lives;
    o_Respawn      = respawn;
    o_Invulnerable = invuln;
    o_Game_Over    = game_over;
    o_State        = state;
  end

endmodule

// File: tb/tb_lives_manager.sv
// tb_lives_manager
// Drives directed scenarios and a randomized run into lives_manager, using
// RESPAWN_CYCLES=4, INVULN_CYCLES=8 and START_LIVES=3. The reference model
// keeps the edge index of the last accepted hit. It derives every output
// window from that index using plain arithmetic.
module tb_lives_manager;

  localparam int R = 4;
  localparam int I = 8;
  localparam int S = 3;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] gs = 2'b00;
  logic       hit = 1'b0;

  logic       collision;
  logic [2:0] lives;
  logic       respawn;
  logic       invuln;
  logic       game_over;
  logic [1:0] state;

  always #5 clk = ~clk;

  lives_manager #(
    .START_LIVES   (S),
    .LIVES_W       (3),
    .RESPAWN_CYCLES(R),
    .INVULN_CYCLES (I)
  ) dut (
    .i_Clk         (clk),
    .i_Reset_N     (rst_n),
    .i_Game_State  (gs),
    .i_Hit         (hit),
    .o_Collision   (collision),
    .o_Lives       (lives),
    .o_Respawn     (respawn),
    .o_Invulnerable(invuln),
    .o_Game_Over   (game_over),
    .o_State       (state)
  );

  int errors = 0;
  int checks = 0;

  // Reference model
  int m_e     = 0;   // index of the most recent clock edge
  int m_h     = -1;  // edge at which the last non-final hit was accepted
  int m_lives = S;
  bit m_dead  = 0;
  bit m_go    = 0;
  bit m_prev  = 0;

  function automatic logic [6:0] obs_v();
    return {collision, lives, respawn, invuln, game_over};
  endfunction

  // Hit at edge h: collision on edges h..h+R-1, respawn on edge h+R,
  // invulnerable on edges h+R..h+R+I-1, re-armed for edges after h+R+I.
  function automatic logic [6:0] exp_vec();
    logic c, rs, iv;
    c  = (m_h >= 0) && (m_e >= m_h) && (m_e <= m_h + R - 1);
    rs = (m_h >= 0) && (m_e == m_h + R);
    iv = (m_h >= 0) && (m_e >= m_h + R) && (m_e <= m_h + R + I - 1);
    return {c, m_lives[2:0], rs, iv, m_go};
  endfunction

  // Driver: one clock edge, then update the model with the sampled inputs.
  task automatic tick();
    logic r, hh, hev, busy;
    logic [1:0] g;
    r  = rst_n;
    hh = hit;
    g  = gs;
    @(posedge clk);
    #1;
    m_e++;
    hev    = hh && !m_prev;
    m_prev = hh;
    m_go   = 0;
    if (!r) begin
      m_lives = S; m_h = -1; m_dead = 0; m_prev = 0;
    end else if (g == 2'b00) begin
      m_lives = S; m_h = -1; m_dead = 0;
    end else begin
      busy = (m_h >= 0) && (m_e <= m_h + R + I);
      if (!m_dead && !busy && g == 2'b01 && hev && m_lives > 0) begin
        if (m_lives > 1) begin
          m_lives--; m_h = m_e;
        end else begin
          m_lives = 0; m_dead = 1; m_go = 1; m_h = -1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gs = 2'b01; hit = 1'b0;
    repeat (2) tick();
    checks++;
    if (obs_v() !== 7'b0_011_000) begin
      errors++;
      $display("FAIL reset outputs got %b required %b", obs_v(), 7'b0_011_000);
    end
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL reset state got %b required 00", state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_hit();
    gs = 2'b01;
    for (int k = 0; k < 20; k++) begin
      hit = (k == 1);
      tick();
      checks++;
      if (obs_v() !== exp_vec()) begin
        errors++;
        $display("FAIL single_hit cyc %0d got %b required %b", k, obs_v(), exp_vec());
      end
    end
    checks++;
    if (lives !== 3'd2) begin
      errors++;
      $display("FAIL single_hit lives got %0d required 2", lives);
    end
  endtask

  task automatic test_long_hold();
    gs = 2'b00; hit = 1'b0; tick();
    gs = 2'b01;
    for (int k = 0; k < 40; k++) begin
      hit = (k >= 1 && k <= 30);
      if (k == 35) hit = 1'b1;
      tick();
      checks++;
      if (obs_v() !== exp_vec()) begin
        errors++;
        $display("FAIL long_hold cyc %0d got %b required %b", k, obs_v(), exp_vec());
      end
      if (k == 34) begin
        checks++;
        if (lives !== 3'd2) begin
          errors++;
          $display("FAIL long_hold lives got %0d required 2", lives);
        end
      end
    end
    hit = 1'b0;
  endtask

  task automatic test_window_hits();
    gs = 2'b00; hit = 1'b0; tick();
    gs = 2'b01;
    for (int k = 0; k < 20; k++) begin
      hit = (k == 0) || (k > 1 && k < 14 && k[0]);
      tick();
      checks++;
      if (obs_v() !== exp_vec()) begin
        errors++;
        $display("FAIL window_hits cyc %0d got %b required %b", k, obs_v(), exp_vec());
      end
    end
    hit = 1'b0;
  endtask

  task automatic test_last_life();
    int gos;
    gos = 0;
    gs = 2'b00; hit = 1'b0; tick();
    gs = 2'b01;
    for (int k = 0; k < 60; k++) begin
      hit = (k == 0) || (k == 16) || (k == 32) || (k == 40) || (k == 50);
      tick();
      gos += int'(game_over);
      checks++;
      if (obs_v() !== exp_vec()) begin
        errors++;
        $display("FAIL last_life cyc %0d got %b required %b", k, obs_v(), exp_vec());
      end
    end
    checks++;
    if (lives !== 3'd0 || gos != 1 || state !== 2'b11) begin
      errors++;
      $display("FAIL last_life end lives=%0d game_over_pulses=%0d state=%b required 0/1/11",
               lives, gos, state);
    end
    hit = 1'b0;
  endtask

  task automatic test_idle_mid();
    int rs;
    rs = 0;
    gs = 2'b00; hit = 1'b0; tick();
    gs = 2'b01;
    for (int k = 0; k < 16; k++) begin
      hit = (k == 0) || (k == 2);
      gs  = (k == 2) ? 2'b00 : 2'b01;
      tick();
      if (k >= 2) rs += int'(respawn);
      checks++;
      if (obs_v() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_mid cyc %0d got %b required %b", k, obs_v(), exp_vec());
      end
      if (k == 2) begin
        checks++;
        if (obs_v() !== 7'b0_011_000 || state !== 2'b00) begin
          errors++;
          $display("FAIL idle_mid reload got %b state %b required 0011000 state 00",
                   obs_v(), state);
        end
      end
    end
    checks++;
    if (rs != 0) begin
      errors++;
      $display("FAIL idle_mid respawn pulses got %0d required 0", rs);
    end
    hit = 1'b0;
  endtask

  task automatic test_gating();
    gs = 2'b00; hit = 1'b0; tick();
    for (int k = 0; k < 40; k++) begin
      gs  = (k < 8) ? 2'b10 : (k < 16) ? 2'b11 : (k < 20) ? 2'b01 : 2'b10;
      hit = (k % 4 == 1) && (k < 18);
      tick();
      checks++;
      if (obs_v() !== exp_vec()) begin
        errors++;
        $display("FAIL gating cyc %0d got %b required %b", k, obs_v(), exp_vec());
      end
    end
    // Reset while inside the invulnerability window
    gs = 2'b01;
    for (int k = 0; k < 12; k++) begin
      hit   = (k == 0);
      rst_n = !(k == 8);
      tick();
      checks++;
      if (obs_v() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_reset cyc %0d got %b required %b", k, obs_v(), exp_vec());
      end
      if (k == 8) begin
        checks++;
        if (obs_v() !== 7'b0_011_000) begin
          errors++;
          $display("FAIL mid_reset outputs got %b required 0011000", obs_v());
        end
      end
    end
    rst_n = 1'b1; hit = 1'b0;
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 600; k++) begin
      r = int'($urandom_range(0, 31));
      gs    = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b01;
      hit   = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
      checks++;
      if (obs_v() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d got %b required %b", k, obs_v(), exp_vec());
      end
      checks++;
      if (collision && invuln) begin
        errors++;
        $display("FAIL random overlap cyc %0d collision and invulnerable both 1, required not both", k);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_long_hold();
    test_window_hits();
    test_last_life();
    test_idle_mid();
    test_gating();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
